axi_burst_sram_slave: RTL and testbench
=======================================

// Module: axi_burst_sram_slave
// PURPOSE
//  AXI3 responder (slave) answering the external-memory master port of the FPGA top level (axm_* bus).
//  Serves 1-16 beat write/read bursts from an on-chip byte-enabled word array.
//  Used as bench/FPGA stand-in for the off-chip SDRAM controller on interconnect port m1.
//  One transaction in flight at a time.
// PARAMETERS
//  AXI_ID_W       4    ID field width
//  AXI_ADDRESS_W  12   byte address width
//  AXI_DATA_W     32   data width; fixed at 32 (assert at elaboration)
//  AXI_NUMBYTES   4    strobe width = AXI_DATA_W/8
//  MEM_WORDS      1024 array depth in words, power of two, <= 2**(AXI_ADDRESS_W-2)
// PORTS
//  clk            in   1   single clock
//  reset_n        in   1   asynchronous, active-low reset
//  s_awid/awaddr/awlen[3:0]/awsize[2:0]/awburst[1:0]  in  -  write address; lock/cache/prot not present
//  s_awvalid in 1; s_awready out 1
//  s_wdata in 32; s_wstrb in 4; s_wlast in 1; s_wvalid in 1; s_wready out 1
//  s_bid out AXI_ID_W; s_bresp out 2; s_bvalid out 1; s_bready in 1
//  s_arid/araddr/arlen/arsize/arburst  in  -  read address; s_arvalid in 1; s_arready out 1
//  s_rid out AXI_ID_W; s_rdata out 32; s_rresp out 2; s_rlast out 1; s_rvalid out 1; s_rready in 1
// BEHAVIOUR
//  Reset: all *ready/*valid, bid, rid, bresp, rresp, rlast, rdata = 0; FSM->IDLE; rr_last=READ.
//   Array contents not reset. Reset mid-burst aborts; already-written beats persist.
//  States: IDLE, WDATA, WRESP, RFETCH, RDATA.
//  IDLE: awready = awvalid & grant_w; arready = arvalid & !grant_w. Only one is high per cycle.
//   Both valid: round-robin (serve opposite of rr_last). Only one valid: serve it.
//   Latch id, word addr = addr[AXI_ADDRESS_W-1:2], len, burst; beat count = 0.
//  WDATA: wready=1; each wvalid beat writes mem[addr] under wstrb.
//   Beat count==len ends burst -> WRESP; wlast is ignored for termination.
//  WRESP: bvalid=1, bid=latched id, bresp=OKAY; hold until bready, then IDLE.
//  RFETCH: one cycle for sync array read -> RDATA.
//  RDATA: rvalid=1, rid, rlast=(count==len), rresp; rdata stable while !rready.
//   On rvalid&rready: last -> IDLE, else advance -> RFETCH.
//   Read throughput = 1 beat / 2 cycles; first rvalid 2 cycles after AR handshake.
//  Address step: burst FIXED(00) keeps addr; INCR(01), WRAP(10), reserved: +1 word.
//   Wraps mod MEM_WORDS (index truncated to log2(MEM_WORDS) bits). awsize/arsize ignored (32-bit).
//  Simultaneous: AW and AR both valid in the same IDLE cycle -> round-robin as above.
//   Write to the word currently being read cannot occur (single transaction).
// CONFIGURATION
//  AXI_SLAVE_BOUNDS_CHECK_EN defined:
//   word addr >= MEM_WORDS at any beat -> that beat returns SLVERR (2'b10), write suppressed, rdata=0.
//   bresp = SLVERR if any beat of the burst erred.
//  Not defined: no check, modulo wrap, resp always OKAY.
// STRUCTURE
//  Package axi_defines_pkg: AXI_RESP_OKAY/SLVERR, AXI_BURST_FIXED/INCR/WRAP constants,
//   slave_state_t enum.
//  Sub-module byte_en_sram: 1 write port with byte enables, 1 synchronous read port, MEM_WORDS x 32.
// TESTING
//  Single write: aw 0x010 len0, w 0xDEADBEEF strb 4'hF -> bvalid next cycle after beat, bresp 0, bid echo.
//  Readback: ar 0x010 len0 id 5 -> rvalid 2 cycles after AR handshake, rdata 0xDEADBEEF, rlast=1, rid=5.
//  Burst + strobes: aw 0x100 len15 INCR, data i, strb 4'h3 on beat 3 -> read 16 beats;
//   beat 3 upper half unchanged; rlast only on beat 15.
//  Backpressure: rready low 5 cycles mid-burst -> rdata/rvalid stable; bready low 4 cycles -> bvalid held.
//  Arbitration: aw and ar valid same IDLE cycle twice in a row -> granted write then read
//   (rr_last=READ after reset).
//  Reset mid-burst: reset_n low after beat 2 of len7 write -> outputs 0 immediately;
//   next transaction completes normally; with AXI_SLAVE_BOUNDS_CHECK_EN, read of word MEM_WORDS
//   returns rresp 2'b10.

Source files
------------

// File: rtl/axi_defines_pkg.sv
// Shared AXI3 encodings and the responder FSM state type for the burst SRAM slave.
package axi_defines_pkg;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

   localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
   localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WDATA  = 3'd1,
      ST_WRESP  = 3'd2,
      ST_RFETCH = 3'd3,
      ST_RDATA  = 3'd4
   } slave_state_t;

   typedef enum logic {
      RR_WRITE = 1'b0,
      RR_READ  = 1'b1
   } rr_dir_t;

endpackage

// File: rtl/byte_en_sram.sv
// Word-organised SRAM: one byte-enabled write port and one synchronous read port.
// The read register only updates when re is high, so the output holds between fetches.
module byte_en_sram #(
   parameter int MEM_WORDS = 1024,
   parameter int NUMBYTES  = 4,
   parameter int IDX_W     = $clog2(MEM_WORDS)
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [IDX_W-1:0]      waddr,
   input  logic [NUMBYTES-1:0]   wstrb,
   input  logic [8*NUMBYTES-1:0] wdata,
   input  logic                  re,
   input  logic [IDX_W-1:0]      raddr,
   output logic [8*NUMBYTES-1:0] rdata
);

   logic [8*NUMBYTES-1:0] mem_q [MEM_WORDS];
   logic [8*NUMBYTES-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < NUMBYTES; b++) begin
            if (wstrb[b]) mem_q[waddr][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
      if (re) rdata_q <= mem_q[raddr];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/axi_burst_sram_slave.sv
// AXI3 burst responder (one transaction in flight) backed by byte_en_sram.
// Define AXI_SLAVE_BOUNDS_CHECK_EN to answer beats at word >= MEM_WORDS with SLVERR instead of wrapping.
module axi_burst_sram_slave
   import axi_defines_pkg::*;
#(
   parameter int AXI_ID_W      = 4,
   parameter int AXI_ADDRESS_W = 12,
   parameter int AXI_DATA_W    = 32,
   parameter int AXI_NUMBYTES  = 4,
   parameter int MEM_WORDS     = 1024
) (
   input  logic                     clk,
   input  logic                     reset_n,

   input  logic [AXI_ID_W-1:0]      s_awid,
   input  logic [AXI_ADDRESS_W-1:0] s_awaddr,
   input  logic [3:0]               s_awlen,
   input  logic [2:0]               s_awsize,
   input  logic [1:0]               s_awburst,
   input  logic                     s_awvalid,
   output logic                     s_awready,

   input  logic [AXI_DATA_W-1:0]    s_wdata,
   input  logic [AXI_NUMBYTES-1:0]  s_wstrb,
   input  logic                     s_wlast,
   input  logic                     s_wvalid,
   output logic                     s_wready,

   output logic [AXI_ID_W-1:0]      s_bid,
   output logic [1:0]               s_bresp,
   output logic                     s_bvalid,
   input  logic                     s_bready,

   input  logic [AXI_ID_W-1:0]      s_arid,
   input  logic [AXI_ADDRESS_W-1:0] s_araddr,
   input  logic [3:0]               s_arlen,
   input  logic [2:0]               s_arsize,
   input  logic [1:0]               s_arburst,
   input  logic                     s_arvalid,
   output logic                     s_arready,

   output logic [AXI_ID_W-1:0]      s_rid,
   output logic [AXI_DATA_W-1:0]    s_rdata,
   output logic [1:0]               s_rresp,
   output logic                     s_rlast,
   output logic                     s_rvalid,
   input  logic                     s_rready
);

   localparam int WA_W  = AXI_ADDRESS_W - 2;
   localparam int IDX_W = $clog2(MEM_WORDS);

   if (AXI_DATA_W != 32 || AXI_NUMBYTES != AXI_DATA_W / 8) begin : g_bad_data_w
      $error("axi_burst_sram_slave: AXI_DATA_W must be 32 with AXI_NUMBYTES = 4");
   end
   if ((1 << IDX_W) != MEM_WORDS || IDX_W > WA_W) begin : g_bad_mem_words
      $error("axi_burst_sram_slave: MEM_WORDS must be a power of two within the address space");
   end

   slave_state_t           state_q, state_d;
   rr_dir_t                rr_last_q, rr_last_d;
   logic                   run_q, run_d;
   logic [AXI_ID_W-1:0]    id_q, id_d;
   logic [WA_W-1:0]        addr_q, addr_d;
   logic [3:0]             len_q, len_d;
   logic [1:0]             burst_q, burst_d;
   logic [3:0]             cnt_q, cnt_d;
   logic                   err_q, err_d;

   logic                   grant_w;
   logic                   aw_go;
   logic                   ar_go;
   logic                   beat_err;
   logic                   mem_we;
   logic                   mem_re;
   logic [AXI_DATA_W-1:0]  mem_rdata;

   logic                   unused_inputs;
   assign unused_inputs = ^{s_awaddr[1:0], s_araddr[1:0], s_awsize, s_arsize, s_wlast};

   function automatic logic [WA_W-1:0] step_addr(input logic [WA_W-1:0] a, input logic [1:0] burst);
      logic [WA_W-1:0] n;
      unique case (burst)
         AXI_BURST_FIXED: n = a;
         AXI_BURST_INCR,
         AXI_BURST_WRAP:  n = a + WA_W'(1);
         default:         n = a + WA_W'(1);
      endcase
      return n;
   endfunction

`ifdef AXI_SLAVE_BOUNDS_CHECK_EN
   localparam logic [WA_W:0] MEM_WORDS_LIM = (WA_W+1)'(MEM_WORDS);
   assign beat_err = ({1'b0, addr_q} >= MEM_WORDS_LIM);
`else
   assign beat_err = 1'b0;
`endif

   byte_en_sram #(
      .MEM_WORDS (MEM_WORDS),
      .NUMBYTES  (AXI_NUMBYTES),
      .IDX_W     (IDX_W)
   ) u_sram (
      .clk   (clk),
      .we    (mem_we),
      .waddr (addr_q[IDX_W-1:0]),
      .wstrb (s_wstrb),
      .wdata (s_wdata),
      .re    (mem_re),
      .raddr (addr_q[IDX_W-1:0]),
      .rdata (mem_rdata)
   );

   assign s_bid = id_q;
   assign s_rid = id_q;

   always_comb begin
      state_d   = state_q;
      rr_last_d = rr_last_q;
      run_d     = 1'b1;
      id_d      = id_q;
      addr_d    = addr_q;
      len_d     = len_q;
      burst_d   = burst_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      s_awready = 1'b0;
      s_arready = 1'b0;
      s_wready  = 1'b0;
      s_bvalid  = 1'b0;
      s_bresp   = AXI_RESP_OKAY;
      s_rvalid  = 1'b0;
      s_rlast   = 1'b0;
      s_rresp   = AXI_RESP_OKAY;
      s_rdata   = '0;
      mem_we    = 1'b0;
      mem_re    = 1'b0;
      aw_go     = 1'b0;
      ar_go     = 1'b0;
      // With both channels requesting, serve the one not served last time.
      grant_w   = s_awvalid && (!s_arvalid || rr_last_q == RR_READ);

      unique case (state_q)
         ST_IDLE: begin
            // run_q keeps both address readys low through the first cycle after reset.
            aw_go     = run_q && s_awvalid && grant_w;
            ar_go     = run_q && s_arvalid && !grant_w;
            s_awready = aw_go;
            s_arready = ar_go;
            if (aw_go) begin
               id_d      = s_awid;
               addr_d    = s_awaddr[AXI_ADDRESS_W-1:2];
               len_d     = s_awlen;
               burst_d   = s_awburst;
               cnt_d     = 4'd0;
               err_d     = 1'b0;
               rr_last_d = RR_WRITE;
               state_d   = ST_WDATA;
            end else if (ar_go) begin
               id_d      = s_arid;
               addr_d    = s_araddr[AXI_ADDRESS_W-1:2];
               len_d     = s_arlen;
               burst_d   = s_arburst;
               cnt_d     = 4'd0;
               err_d     = 1'b0;
               rr_last_d = RR_READ;
               state_d   = ST_RFETCH;
            end
         end
         ST_WDATA: begin
            s_wready = 1'b1;
            if (s_wvalid) begin
               mem_we = !beat_err;
               err_d  = err_q | beat_err;
               // Burst length alone terminates the burst; wlast is not consulted.
               if (cnt_q == len_q) begin
                  state_d = ST_WRESP;
               end else begin
                  cnt_d  = cnt_q + 4'd1;
                  addr_d = step_addr(addr_q, burst_q);
               end
            end
         end
         ST_WRESP: begin
            s_bvalid = 1'b1;
            s_bresp  = err_q ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            if (s_bready) state_d = ST_IDLE;
         end
         ST_RFETCH: begin
            mem_re  = 1'b1;
            state_d = ST_RDATA;
         end
         ST_RDATA: begin
            s_rvalid = 1'b1;
            s_rlast  = (cnt_q == len_q);
            s_rresp  = beat_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            s_rdata  = beat_err ? '0 : mem_rdata;
            if (s_rready) begin
               if (cnt_q == len_q) begin
                  state_d = ST_IDLE;
               end else begin
                  cnt_d   = cnt_q + 4'd1;
                  addr_d  = step_addr(addr_q, burst_q);
                  state_d = ST_RFETCH;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         rr_last_q <= RR_READ;
         run_q     <= 1'b0;
         id_q      <= '0;
         addr_q    <= '0;
         len_q     <= '0;
         burst_q   <= AXI_BURST_INCR;
         cnt_q     <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         rr_last_q <= rr_last_d;
         run_q     <= run_d;
         id_q      <= id_d;
         addr_q    <= addr_d;
         len_q     <= len_d;
         burst_q   <= burst_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
      end
   end

endmodule

// File: tb/tb_axi_burst_sram_slave.sv
// Scoreboard bench for axi_burst_sram_slave (MEM_WORDS = 512 so word 512 is addressable).
// Expected B/R responses are queued from a reference memory when stimulus is driven.
module tb_axi_burst_sram_slave;

   localparam int ID_W = 4;
   localparam int AW   = 12;
   localparam int MW   = 512;

   logic            clk = 1'b0;
   logic            reset_n = 1'b0;
   logic [ID_W-1:0] s_awid = '0;
   logic [AW-1:0]   s_awaddr = '0;
   logic [3:0]      s_awlen = '0;
   logic [2:0]      s_awsize = 3'd2;
   logic [1:0]      s_awburst = 2'b01;
   logic            s_awvalid = 1'b0;
   logic            s_awready;
   logic [31:0]     s_wdata = '0;
   logic [3:0]      s_wstrb = '0;
   logic            s_wlast = 1'b0;
   logic            s_wvalid = 1'b0;
   logic            s_wready;
   logic [ID_W-1:0] s_bid;
   logic [1:0]      s_bresp;
   logic            s_bvalid;
   logic            s_bready = 1'b1;
   logic [ID_W-1:0] s_arid = '0;
   logic [AW-1:0]   s_araddr = '0;
   logic [3:0]      s_arlen = '0;
   logic [2:0]      s_arsize = 3'd2;
   logic [1:0]      s_arburst = 2'b01;
   logic            s_arvalid = 1'b0;
   logic            s_arready;
   logic [ID_W-1:0] s_rid;
   logic [31:0]     s_rdata;
   logic [1:0]      s_rresp;
   logic            s_rlast;
   logic            s_rvalid;
   logic            s_rready = 1'b1;

   always #5 clk = ~clk;

   axi_burst_sram_slave #(
      .AXI_ID_W(ID_W), .AXI_ADDRESS_W(AW), .AXI_DATA_W(32), .AXI_NUMBYTES(4), .MEM_WORDS(MW)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
      .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
      .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
      .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
      .s_rvalid(s_rvalid), .s_rready(s_rready)
   );

   typedef struct packed {
      logic [ID_W-1:0] id;
      logic [31:0]     data;
      logic [1:0]      resp;
      logic            last;
   } r_exp_t;

   typedef struct packed {
      logic [ID_W-1:0] id;
      logic [1:0]      resp;
   } b_exp_t;

   r_exp_t      r_q[$];
   b_exp_t      b_q[$];
   logic [31:0] model [MW];
   logic [31:0] wd [16];
   logic [3:0]  ws [16];
   int          n_checks = 0;
   int          n_errors = 0;
   int          rx_cnt = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic bad(input logic [9:0] w);
`ifdef AXI_SLAVE_BOUNDS_CHECK_EN
      return w >= 10'(MW);
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [9:0] nxt(input logic [9:0] w, input logic [1:0] burst);
      return (burst == 2'b00) ? w : w + 10'd1;
   endfunction

   task automatic model_write(input logic [9:0] w, input logic [31:0] d, input logic [3:0] strb);
      if (!bad(w)) begin
         for (int b = 0; b < 4; b++) begin
            if (strb[b]) model[w[8:0]][8*b +: 8] = d[8*b +: 8];
         end
      end
   endtask

   task automatic push_b(input logic [3:0] id, input logic [9:0] w0, input logic [3:0] len,
                         input logic [1:0] burst);
      logic       e;
      logic [9:0] w;
      e = 1'b0;
      w = w0;
      for (int i = 0; i <= int'(len); i++) begin
         e = e | bad(w);
         w = nxt(w, burst);
      end
      b_q.push_back('{id: id, resp: (e ? 2'b10 : 2'b00)});
   endtask

   task automatic push_r(input logic [3:0] id, input logic [9:0] w0, input logic [3:0] len,
                         input logic [1:0] burst);
      logic [9:0] w;
      w = w0;
      for (int i = 0; i <= int'(len); i++) begin
         r_q.push_back('{id: id, data: (bad(w) ? 32'h0 : model[w[8:0]]),
                         resp: (bad(w) ? 2'b10 : 2'b00), last: (i == int'(len))});
         w = nxt(w, burst);
      end
   endtask

   task automatic send_aw(input logic [3:0] id, input logic [11:0] addr, input logic [3:0] len,
                          input logic [1:0] burst);
      int t;
      s_awid = id; s_awaddr = addr; s_awlen = len; s_awburst = burst; s_awvalid = 1'b1;
      t = 0;
      do begin @(negedge clk); t++; end while (!s_awready && t < 100);
      check("aw_handshake", s_awready, 1'b1);
      push_b(id, addr[11:2], len, burst);
      @(posedge clk); #1;
      s_awvalid = 1'b0;
   endtask

   task automatic send_w(input logic [9:0] w0, input logic [3:0] len, input logic [1:0] burst,
                         input int nbeats);
      logic [9:0] w;
      int         t;
      w = w0;
      for (int i = 0; i < nbeats; i++) begin
         s_wdata = wd[i]; s_wstrb = ws[i]; s_wlast = (i == int'(len)); s_wvalid = 1'b1;
         t = 0;
         do begin @(negedge clk); t++; end while (!s_wready && t < 100);
         check("w_handshake", s_wready, 1'b1);
         model_write(w, wd[i], ws[i]);
         w = nxt(w, burst);
         @(posedge clk); #1;
      end
      s_wvalid = 1'b0; s_wlast = 1'b0;
   endtask

   task automatic send_ar(input logic [3:0] id, input logic [11:0] addr, input logic [3:0] len,
                          input logic [1:0] burst);
      int t;
      s_arid = id; s_araddr = addr; s_arlen = len; s_arburst = burst; s_arvalid = 1'b1;
      push_r(id, addr[11:2], len, burst);
      t = 0;
      do begin @(negedge clk); t++; end while (!s_arready && t < 100);
      check("ar_handshake", s_arready, 1'b1);
      @(posedge clk); #1;
      s_arvalid = 1'b0;
   endtask

   task automatic drain(input string tag);
      int t;
      t = 0;
      while ((r_q.size() != 0 || b_q.size() != 0) && t < 1000) begin
         @(posedge clk);
         t++;
      end
      check(tag, 64'(r_q.size() + b_q.size()), 64'd0);
      @(posedge clk); #1;
   endtask

   task automatic check_idle_outputs(input string tag);
      check(tag, {s_awready, s_arready, s_wready, s_bvalid, s_rvalid, s_rlast,
                  s_bresp, s_rresp, s_bid, s_rid, s_rdata}, 64'd0);
   endtask

   always @(negedge clk) begin : monitor
      r_exp_t re;
      b_exp_t be;
      if (reset_n && s_rvalid && s_rready) begin
         if (r_q.size() == 0) begin
            check("r_unexpected", 1'b1, 1'b0);
         end else begin
            re = r_q.pop_front();
            check("rid", s_rid, re.id);
            check("rdata", s_rdata, re.data);
            check("rresp", s_rresp, re.resp);
            check("rlast", s_rlast, re.last);
         end
         rx_cnt++;
      end
      if (reset_n && s_bvalid && s_bready) begin
         if (b_q.size() == 0) begin
            check("b_unexpected", 1'b1, 1'b0);
         end else begin
            be = b_q.pop_front();
            check("bid", s_bid, be.id);
            check("bresp", s_bresp, be.resp);
         end
      end
   end

   initial begin
      int          t;
      int          base;
      logic [31:0] held;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_idle_outputs("reset_outputs");
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;

      // single write, then readback with latency checks
      wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
      send_aw(4'h3, 12'h010, 4'd0, 2'b01);
      send_w(10'h004, 4'd0, 2'b01, 1);
      check("bvalid_next_cycle", s_bvalid, 1'b1);
      check("bid_echo", s_bid, 4'h3);
      drain("drain_single_write");
      send_ar(4'h5, 12'h010, 4'd0, 2'b01);
      check("rvalid_in_fetch", s_rvalid, 1'b0);
      @(posedge clk); #1;
      check("rvalid_two_cycles", s_rvalid, 1'b1);
      drain("drain_single_read");

      // 16-beat INCR burst over a prefilled region, beat 3 lower half only
      for (int i = 0; i < 16; i++) begin wd[i] = 32'hA5A5_0000 | i; ws[i] = 4'hF; end
      send_aw(4'h1, 12'h100, 4'd15, 2'b01);
      send_w(10'h040, 4'd15, 2'b01, 16);
      drain("drain_prefill");
      for (int i = 0; i < 16; i++) begin wd[i] = i; ws[i] = 4'hF; end
      ws[3] = 4'h3;
      send_aw(4'h2, 12'h100, 4'd15, 2'b01);
      send_w(10'h040, 4'd15, 2'b01, 16);
      drain("drain_burst_write");

      // read it back with rready low mid-burst
      base = rx_cnt;
      send_ar(4'h7, 12'h100, 4'd15, 2'b01);
      t = 0;
      while (rx_cnt < base + 4 && t < 200) begin @(posedge clk); t++; end
      check("rx_progress", 64'(rx_cnt >= base + 4), 64'd1);
      #1;
      s_rready = 1'b0;
      t = 0;
      do begin @(negedge clk); t++; end while (!s_rvalid && t < 100);
      held = s_rdata;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("rvalid_held", s_rvalid, 1'b1);
         check("rdata_held", s_rdata, held);
      end
      @(posedge clk); #1;
      s_rready = 1'b1;
      drain("drain_burst_read");

      // FIXED burst with bready backpressure
      for (int i = 0; i < 4; i++) begin wd[i] = 32'h0000_1000 + i; ws[i] = 4'hF; end
      ws[3] = 4'hC;
      s_bready = 1'b0;
      send_aw(4'h4, 12'h0C0, 4'd3, 2'b00);
      send_w(10'h030, 4'd3, 2'b00, 4);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("bvalid_held", s_bvalid, 1'b1);
      end
      @(posedge clk); #1;
      s_bready = 1'b1;
      drain("drain_fixed_write");
      send_ar(4'h6, 12'h0C0, 4'd0, 2'b00);
      drain("drain_fixed_read");

      // reset in the middle of an 8-beat write
      for (int i = 0; i < 8; i++) begin wd[i] = 32'hC0DE_0000 + i; ws[i] = 4'hF; end
      send_aw(4'h2, 12'h200, 4'd7, 2'b01);
      send_w(10'h080, 4'd7, 2'b01, 3);
      reset_n = 1'b0;
      #1;
      check_idle_outputs("reset_mid_burst");
      b_q.delete();
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(posedge clk); #1;

      // simultaneous AW/AR twice: write first, then read
      wd[0] = 32'h1234_5678; wd[1] = 32'h9ABC_DEF0; ws[0] = 4'hF; ws[1] = 4'hF;
      s_awid = 4'h8; s_awaddr = 12'h300; s_awlen = 4'd1; s_awburst = 2'b01; s_awvalid = 1'b1;
      s_arid = 4'h9; s_araddr = 12'h300; s_arlen = 4'd1; s_arburst = 2'b01; s_arvalid = 1'b1;
      @(negedge clk);
      check("arb1_awready", s_awready, 1'b1);
      check("arb1_arready", s_arready, 1'b0);
      push_b(4'h8, 10'h0C0, 4'd1, 2'b01);
      @(posedge clk); #1;
      s_awvalid = 1'b0;
      send_w(10'h0C0, 4'd1, 2'b01, 2);
      s_awid = 4'hA; s_awaddr = 12'h340; s_awlen = 4'd0; s_awvalid = 1'b1;
      t = 0;
      do begin @(negedge clk); t++; end while (!(s_awready || s_arready) && t < 100);
      check("arb2_arready", s_arready, 1'b1);
      check("arb2_awready", s_awready, 1'b0);
      push_r(4'h9, 10'h0C0, 4'd1, 2'b01);
      @(posedge clk); #1;
      s_arvalid = 1'b0;
      t = 0;
      do begin @(negedge clk); t++; end while (!s_awready && t < 100);
      check("arb3_awready", s_awready, 1'b1);
      push_b(4'hA, 10'h0D0, 4'd0, 2'b01);
      @(posedge clk); #1;
      s_awvalid = 1'b0;
      wd[0] = 32'h0BAD_F00D;
      send_w(10'h0D0, 4'd0, 2'b01, 1);
      drain("drain_arbitration");

      // beats written before the reset persist
      send_ar(4'h1, 12'h200, 4'd2, 2'b01);
      drain("drain_persisted");

      // top of array: word 511 then word 512 (wraps, or errs with bounds checking)
      wd[0] = 32'h1111_1111; wd[1] = 32'h2222_2222; ws[0] = 4'hF; ws[1] = 4'hF;
      send_aw(4'hB, 12'h7FC, 4'd1, 2'b01);
      send_w(10'h1FF, 4'd1, 2'b01, 2);
      drain("drain_edge_write");
      send_ar(4'hC, 12'h7FC, 4'd1, 2'b01);
      drain("drain_edge_read");
      send_ar(4'hD, 12'h800, 4'd0, 2'b01);
      drain("drain_word_mem_words");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
